disp_seq_ctrl: RTL and testbench

Step scheduler for the display sequencer. It runs a programmable list of display steps. Each step holds for a configured number of milliseconds, counted from the 1 ms LFSR timer's timeout pulse. The block drives the timer's enable and clear, and presents the current step index to the display datapath. It sits between the top-level start/stop controls and the timer/pattern ROM.

---
 rtl/disp_seq_pkg.sv | 17 +
 rtl/disp_dur_table.sv | 30 +++
 rtl/disp_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_disp_seq_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_seq_pkg.sv
// Shared types and default sizing for the display step sequencer.
package disp_seq_pkg;

  localparam int unsigned NUM_STEPS_DEF = 8;
  localparam int unsigned DUR_W_DEF     = 10;
  localparam int unsigned IDX_W_DEF     = 3;
  localparam int unsigned DUR_SKIP      = 0;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    PAUSED,
    ADV
  } state_t;

endpackage

// File: rtl/disp_dur_table.sv
// Per-step duration register file: one write port, asynchronous read.
module disp_dur_table
  import disp_seq_pkg::*;
#(
  parameter int unsigned NUM_STEPS = NUM_STEPS_DEF,
  parameter int unsigned DUR_W     = DUR_W_DEF,
  parameter int unsigned IDX_W     = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [DUR_W-1:0] wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [DUR_W-1:0] rdata
);

  logic [DUR_W-1:0] mem [NUM_STEPS];

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem <= '{default: '0};
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/disp_seq_ctrl.sv
// Step scheduler: holds each display step for its programmed number of
// millisecond ticks, driving the ms timer and presenting the step index.
module disp_seq_ctrl
  import disp_seq_pkg::*;
#(
  parameter int unsigned NUM_STEPS = NUM_STEPS_DEF,
  parameter int unsigned DUR_W     = DUR_W_DEF,
  parameter int unsigned IDX_W     = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             loop_en,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [DUR_W-1:0] cfg_data,
  input  logic             ms_tick,
  output logic             tmr_en,
  output logic             tmr_clr_n,
  output logic [IDX_W-1:0] step_idx,
  output logic             busy,
  output logic             step_start,
  output logic             done
);

  state_t           state, state_n;
  logic [IDX_W-1:0] idx_n;
  logic [DUR_W-1:0] counter, cnt_n;
  logic [DUR_W-1:0] dur;
  logic             tick_q, tick;

  disp_dur_table #(
    .NUM_STEPS (NUM_STEPS),
    .DUR_W     (DUR_W),
    .IDX_W     (IDX_W)
  ) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (step_idx),
    .rdata (dur)
  );

  // The timer holds its timeout high while disabled, so count rising edges only.
  assign tick = ms_tick & ~tick_q;
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      step_idx <= '0;
      counter  <= '0;
      tick_q   <= 1'b0;
    end else begin
      state    <= state_n;
      step_idx <= idx_n;
      counter  <= cnt_n;
      tick_q   <= ms_tick;
    end
  end

  always_comb begin
    state_n    = state;
    idx_n      = step_idx;
    cnt_n      = counter;
    tmr_en     = 1'b0;
    tmr_clr_n  = 1'b1;
    step_start = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        tmr_clr_n = 1'b0;
        if (start && !stop) begin
          state_n = LOAD;
          idx_n   = '0;
        end
      end
      LOAD: begin
        tmr_clr_n = 1'b0;
        if (stop) begin
          state_n = IDLE;
          idx_n   = '0;
        end else begin
          cnt_n = dur;
          if (dur == DUR_W'(DUR_SKIP)) begin
            state_n = ADV;
          end else begin
            state_n    = RUN;
            step_start = 1'b1;
          end
        end
      end
      RUN: begin
        tmr_en = 1'b1;
        if (stop) begin
          state_n = IDLE;
          idx_n   = '0;
        end else if (pause) begin
          state_n = PAUSED;
        end else if (tick) begin
          if (counter == DUR_W'(1)) state_n = ADV;
          else                      cnt_n   = counter - 1'b1;
        end
      end
      PAUSED: begin
        if (stop) begin
          state_n = IDLE;
          idx_n   = '0;
        end else if (!pause) begin
          state_n = RUN;
        end
      end
      ADV: begin
        if (stop) begin
          state_n = IDLE;
          idx_n   = '0;
        end else if (step_idx != IDX_W'(NUM_STEPS - 1)) begin
          state_n = LOAD;
          idx_n   = step_idx + 1'b1;
        end else if (loop_en) begin
          state_n = LOAD;
          idx_n   = '0;
        end else begin
          state_n = IDLE;
          done    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_disp_seq_ctrl.sv
// Directed bench for disp_seq_ctrl: table-driven step durations plus
// hand-written sequences for skip, held tick, pause, loop/stop and live rewrite.
module tb_disp_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, stop, pause, loop_en, cfg_we, ms_tick;
  logic [2:0] cfg_addr;
  logic [9:0] cfg_data;
  logic       tmr_en, tmr_clr_n, busy, step_start, done;
  logic [2:0] step_idx;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;
  int unsigned done_cnt = 0;
  int unsigned ss_cnt   = 0;

  typedef struct {
    logic [9:0]  dur;
    int unsigned exp_ticks;
  } step_vec_t;

  step_vec_t vecs [8];

  disp_seq_ctrl #(.NUM_STEPS(8), .DUR_W(10), .IDX_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .loop_en    (loop_en),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .ms_tick    (ms_tick),
    .tmr_en     (tmr_en),
    .tmr_clr_n  (tmr_clr_n),
    .step_idx   (step_idx),
    .busy       (busy),
    .step_start (step_start),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done)       done_cnt++;
    if (step_start) ss_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; ms_tick = 1'b0;
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [9:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic send_tick();
    ms_tick = 1'b1;
    cyc();
    ms_tick = 1'b0;
    repeat (19) cyc();
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
  endtask

  // Ticks delivered until the step index moves away or the sequence ends.
  task automatic count_ticks(input logic [2:0] from_idx, output int unsigned n);
    n = 0;
    while (step_idx == from_idx && busy && n < 40) begin
      send_tick();
      n++;
    end
  endtask

  initial begin
    int unsigned n, base_done, base_ss, bad;

    vecs[0] = '{dur: 10'd3, exp_ticks: 3};
    vecs[1] = '{dur: 10'd1, exp_ticks: 1};
    vecs[2] = '{dur: 10'd2, exp_ticks: 2};
    vecs[3] = '{dur: 10'd4, exp_ticks: 4};
    vecs[4] = '{dur: 10'd1, exp_ticks: 1};
    vecs[5] = '{dur: 10'd2, exp_ticks: 2};
    vecs[6] = '{dur: 10'd3, exp_ticks: 3};
    vecs[7] = '{dur: 10'd1, exp_ticks: 1};

    // Reset state and start latency, then the table-driven durations.
    rst = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; ms_tick = 1'b0;
    repeat (2) cyc();
    check("rst_tmr_en", int'(tmr_en), 0);
    check("rst_tmr_clr_n", int'(tmr_clr_n), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_step_idx", int'(step_idx), 0);
    check("rst_pulses", int'({step_start, done}), 0);
    rst = 1'b1;
    cyc();
    for (int unsigned i = 0; i < 8; i++) cfg_write(3'(i), vecs[i].dur);
    base_done = done_cnt; base_ss = ss_cnt;
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("load_step_start", int'(step_start), 1);
    check("load_tmr_en", int'(tmr_en), 0);
    check("load_busy", int'(busy), 1);
    cyc();
    check("run_tmr_en", int'(tmr_en), 1);
    check("run_tmr_clr_n", int'(tmr_clr_n), 1);
    for (int unsigned i = 0; i < 8; i++) begin
      count_ticks(3'(i), n);
      check($sformatf("step%0d_ticks", i), int'(n), int'(vecs[i].exp_ticks));
      if (i < 7) check($sformatf("step%0d_next", i), int'(step_idx), int'(i + 1));
    end
    check("end_busy", int'(busy), 0);
    check("end_step_idx", int'(step_idx), 7);
    check("end_done_pulses", int'(done_cnt - base_done), 1);
    check("end_step_starts", int'(ss_cnt - base_ss), 8);

    // Zero-duration step is skipped without a step_start.
    apply_reset();
    cfg_write(3'd0, 10'd2);
    cfg_write(3'd2, 10'd5);
    for (int unsigned i = 3; i < 8; i++) cfg_write(3'(i), 10'd1);
    base_ss = ss_cnt;
    do_start();
    count_ticks(3'd0, n);
    check("skip_step0_ticks", int'(n), 2);
    check("skip_idx", int'(step_idx), 2);
    check("skip_step_starts", int'(ss_cnt - base_ss), 2);
    count_ticks(3'd2, n);
    check("skip_step2_ticks", int'(n), 5);

    // A held ms_tick counts once.
    apply_reset();
    for (int unsigned i = 0; i < 8; i++) cfg_write(3'(i), 10'd3);
    do_start();
    ms_tick = 1'b1;
    repeat (50) cyc();
    ms_tick = 1'b0;
    cyc();
    check("held_counter", int'(dut.counter), 2);
    check("held_idx", int'(step_idx), 0);
    count_ticks(3'd0, n);
    check("held_remaining", int'(n), 2);

    // Pause mid-step with a coincident tick discarded.
    apply_reset();
    cfg_write(3'd0, 10'd1);
    cfg_write(3'd1, 10'd1);
    cfg_write(3'd2, 10'd5);
    do_start();
    send_tick();
    send_tick();
    check("pause_idx", int'(step_idx), 2);
    send_tick();
    send_tick();
    check("pause_pre_counter", int'(dut.counter), 3);
    pause = 1'b1; ms_tick = 1'b1;
    cyc();
    ms_tick = 1'b0;
    bad = 0;
    for (int unsigned k = 0; k < 100; k++) begin
      ms_tick = (k == 50);
      cyc();
      if (tmr_en !== 1'b0 || dut.counter != 10'd3 || !busy) bad++;
    end
    ms_tick = 1'b0;
    check("pause_hold_violations", int'(bad), 0);
    pause = 1'b0;
    cyc();
    check("resume_tmr_en", int'(tmr_en), 1);
    count_ticks(3'd2, n);
    check("resume_ticks", int'(n), 3);

    // Looping wrap with no done, then stop.
    apply_reset();
    loop_en = 1'b1;
    for (int unsigned i = 0; i < 8; i++) cfg_write(3'(i), 10'd1);
    base_done = done_cnt;
    do_start();
    repeat (8) send_tick();
    check("loop_wrap_idx", int'(step_idx), 0);
    check("loop_busy", int'(busy), 1);
    check("loop_no_done", int'(done_cnt - base_done), 0);
    repeat (3) send_tick();
    check("loop_idx3", int'(step_idx), 3);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("stop_busy", int'(busy), 0);
    check("stop_idx", int'(step_idx), 0);
    check("stop_tmr_en", int'(tmr_en), 0);
    check("stop_no_done", int'(done_cnt - base_done), 0);

    // Rewrite of the active step's duration applies on the next pass.
    apply_reset();
    loop_en = 1'b1;
    cfg_write(3'd0, 10'd4);
    for (int unsigned i = 1; i < 8; i++) cfg_write(3'(i), 10'd1);
    do_start();
    send_tick();
    cfg_write(3'd0, 10'd9);
    count_ticks(3'd0, n);
    check("rewrite_cur_ticks", int'(n), 3);
    repeat (7) send_tick();
    check("rewrite_wrap_idx", int'(step_idx), 0);
    count_ticks(3'd0, n);
    check("rewrite_next_ticks", int'(n), 9);
    rst = 1'b0;
    cyc();
    check("midrst_tmr_en", int'(tmr_en), 0);
    check("midrst_tmr_clr_n", int'(tmr_clr_n), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_idx", int'(step_idx), 0);
    check("midrst_pulses", int'({step_start, done}), 0);
    rst = 1'b1;
    loop_en = 1'b0;
    cyc();
    base_done = done_cnt; base_ss = ss_cnt;
    do_start();
    repeat (30) cyc();
    check("cleared_done", int'(done_cnt - base_done), 1);
    check("cleared_no_step_start", int'(ss_cnt - base_ss), 0);
    check("cleared_busy", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
